// File: rtl/random_handshake_delay.sv
// random_handshake_delay: LFSR-driven per-channel request/ack delay injector with stall counter.
// Every channel reads the same shared LFSR snapshot; a mode change aborts all in-flight handshakes.
module random_handshake_delay #(
    parameter int NUM_CH = 5,
    parameter int LFSR_W = 23,
    parameter int TAP_B = 17,
    parameter logic [LFSR_W-1:0] SEED = 23'h557EA2,
    parameter int DLY_W = 4,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] ack,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [LFSR_W-1:0] lfsr_state
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    logic [LFSR_W-1:0] lfsr;
    logic [1:0]        mode_q;
    logic [NUM_CH-1:0] ack_vec, waiting, active;
    logic              flush;
    assign flush = (mode != mode_q) || (mode == 2'd1);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           st;
        logic [DLY_W-1:0] cnt, raw, dly;
        logic             ack_r;
        for (genvar k = 0; k < DLY_W; k++) begin : g_bit
            assign raw[k] = lfsr[(3*i+k) % LFSR_W];
        end
        assign dly = (mode == 2'd3) ? {DLY_W{1'b1}} : (mode == 2'd2) ? (raw & DLY_W'(3)) : raw;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st    <= S_IDLE;
                cnt   <= '0;
                ack_r <= 1'b0;
            end else if (flush) begin
                st    <= S_IDLE;
                ack_r <= 1'b0;
            end else begin
                case (st)
                    S_IDLE: if (req[i]) begin
                        st  <= S_WAIT;
                        cnt <= dly;
                    end
                    S_WAIT: if (!req[i]) st <= S_IDLE;
                    else if (cnt == '0) begin
                        st    <= S_ACK;
                        ack_r <= 1'b1;
                    end else cnt <= cnt - 1'b1;
                    default: begin
                        st    <= S_IDLE;
                        ack_r <= 1'b0;
                    end
                endcase
            end
        end
        assign ack_vec[i] = ack_r;
        assign waiting[i] = (st == S_WAIT);
        assign active[i]  = (st != S_IDLE);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr      <= SEED;
            mode_q    <= 2'd0;
            stall_cnt <= '0;
        end else begin
            lfsr      <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[TAP_B]};
            mode_q    <= mode;
            stall_cnt <= stall_cnt + CNT_W'(|waiting && !(&stall_cnt));
        end
    end
    // pass-through mode bypasses the registered pulse entirely
    assign ack        = (mode == 2'd1) ? req : ack_vec;
    assign busy       = |active;
    assign lfsr_state = lfsr;
endmodule

// File: tb/tb_random_handshake_delay.sv
// tb_random_handshake_delay: randomized scoreboard bench against a deadline-based reference model.
// A second instance with a 4-bit stall counter exercises saturation on the same stimulus.
module tb_random_handshake_delay;
    localparam int NCH = 5;
    localparam logic [22:0] SEED = 23'h557EA2;
    typedef struct {int due; int start; int m;} ent_t;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [4:0]  req = '0;
    logic [4:0]  ack, ack4;
    logic        busy, busy4;
    logic [31:0] stall;
    logic [3:0]  stall4;
    logic [22:0] lfsr, lfsr4;
    int          checks = 0, errors = 0;
    int          n = 0;
    logic [22:0] m_lfsr = SEED;
    logic [1:0]  mq = 2'd0;
    longint      m_stall = 0;
    bit          act [NCH];
    int          due [NCH];
    ent_t        sbq [NCH][$];

    random_handshake_delay dut (.clk(clk), .reset(reset), .mode(mode), .req(req), .ack(ack),
        .busy(busy), .stall_cnt(stall), .lfsr_state(lfsr));
    random_handshake_delay #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .mode(mode), .req(req),
        .ack(ack4), .busy(busy4), .stall_cnt(stall4), .lfsr_state(lfsr4));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, got, exp, n, $time);
        end
    endtask

    function automatic logic [22:0] lfsr_step(input logic [22:0] l);
        return ((l << 1) & 23'h7FFFFF) | 23'(l[22] ^ l[17]);
    endfunction

    function automatic int delay_of(input logic [22:0] l, input int ch, input logic [1:0] m);
        int d = 0;
        for (int k = 0; k < 4; k++) d += l[(3*ch+k) % 23] ? (1 << k) : 0;
        return (m == 2'd3) ? 15 : (m == 2'd2) ? d % 4 : d;
    endfunction

    function automatic bit any_active();
        for (int c = 0; c < NCH; c++) if (act[c]) return 1'b1;
        return 1'b0;
    endfunction

    // Each request is a window [sample edge, due]; ack appears right after edge due, cleared one edge later.
    task automatic model_edge();
        bit   chg, anyw;
        ent_t e;
        chg = (mode != mq);
        anyw = 0;
        for (int c = 0; c < NCH; c++) if (act[c] && n <= due[c]) anyw = 1;
        if (anyw && m_stall < 64'hFFFFFFFF) m_stall++;
        for (int c = 0; c < NCH; c++) begin
            if (chg || mode == 2'd1) begin
                act[c] = 0;
                sbq[c].delete();
            end else if (act[c] && n <= due[c]) begin
                if (!req[c]) begin
                    act[c] = 0;
                    sbq[c].delete();
                end
            end else if (act[c]) act[c] = 0;
            else if (req[c]) begin
                act[c] = 1;
                due[c] = n + delay_of(m_lfsr, c, mode) + 1;
                e.due = due[c];
                e.start = n;
                e.m = int'(mode);
                sbq[c].push_back(e);
            end
        end
        m_lfsr = lfsr_step(m_lfsr);
        mq = mode;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr = SEED;
            mq = 2'd0;
            m_stall = 0;
            for (int c = 0; c < NCH; c++) begin
                act[c] = 0;
                sbq[c].delete();
            end
        end else begin
            n++;
            model_edge();
        end
    end

    task automatic monitor_cycle();
        logic [4:0] expv;
        ent_t       e;
        int         lat;
        bit         ok;
        chk("lfsr_state", lfsr, m_lfsr);
        chk("lfsr_state_sat_inst", lfsr4, m_lfsr);
        chk("stall_cnt", stall, m_stall);
        chk("stall_cnt_saturating", stall4, (m_stall > 15) ? 15 : m_stall);
        chk("busy", busy, any_active());
        chk("busy_sat_inst", busy4, any_active());
        if (mode == 2'd1) begin
            chk("ack_passthrough", ack, req);
            chk("ack_passthrough_sat_inst", ack4, req);
        end else begin
            expv = '0;
            for (int c = 0; c < NCH; c++) expv[c] = (sbq[c].size() > 0 && sbq[c][0].due == n);
            chk("ack_sat_inst", ack4, expv);
            for (int c = 0; c < NCH; c++) begin
                if (ack[c]) begin
                    if (sbq[c].size() == 0) chk($sformatf("ack%0d_unexpected", c), 1, 0);
                    else begin
                        e = sbq[c].pop_front();
                        chk($sformatf("ack%0d_edge", c), n, e.due);
                        lat = n - e.start;
                        ok = (e.m == 3) ? (lat == 16) : (e.m == 2) ? (lat >= 1 && lat <= 4) : (lat >= 1 && lat <= 16);
                        chk($sformatf("ack%0d_latency_in_range", c), ok, 1);
                    end
                end else if (sbq[c].size() > 0 && sbq[c][0].due <= n) begin
                    e = sbq[c].pop_front();
                    chk($sformatf("ack%0d_missing_due_edge", c), n, e.due);
                end
            end
        end
    endtask

    always @(negedge clk) if (!reset) monitor_cycle();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        reset = 1'b1;
        req = '0;
        mode = m;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int busy_cycles, ack_at, nacks, acks;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lfsr", lfsr, 23'h557EA2);
        chk("reset_ack", ack, 0);
        chk("reset_stall", stall, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("first_edge_lfsr", lfsr, 23'h2AFD45);
        chk("first_edge_ack", ack, 0);
        chk("first_edge_busy", busy, 0);

        do_reset(2'd3);
        req[0] = 1'b1;
        busy_cycles = 0;
        ack_at = -1;
        nacks = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_cycles++;
            if (ack[0]) begin
                nacks++;
                ack_at = k;
            end
            if (k == 17) req = '0;
        end
        chk("fixed_max_ack_edge", ack_at, 16);
        chk("fixed_max_ack_pulses", nacks, 1);
        chk("fixed_max_busy_cycles", busy_cycles, 17);
        chk("fixed_max_stall", stall, 16);
        chk("fixed_max_stall_sat4", stall4, 15);

        do_reset(2'd1);
        req = 5'b10101;
        #1;
        chk("passthru_ack_a", ack, 5'b10101);
        chk("passthru_busy", busy, 0);
        repeat (3) tick();
        req = 5'b01010;
        #1;
        chk("passthru_ack_b", ack, 5'b01010);
        tick();
        chk("passthru_stall", stall, 0);

        for (int run = 0; run < 2; run++) begin
            do_reset(2'd2);
            req = '1;
            acks = 0;
            repeat (1000) begin
                tick();
                acks += $countones(ack);
            end
            chk("short_mode_ack_volume", acks >= 700, 1);
        end

        do_reset(2'd3);
        req[1] = 1'b1;
        repeat (5) tick();
        req[1] = 1'b0;
        nacks = 0;
        repeat (10) begin
            tick();
            if (ack[1]) nacks++;
        end
        chk("abort_no_ack", nacks, 0);
        chk("abort_stall", stall, 5);
        chk("abort_busy", busy, 0);

        do_reset(2'd3);
        req[0] = 1'b1;
        repeat (6) tick();
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_ack", ack, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_stall", stall, 0);
        chk("async_reset_lfsr", lfsr, 23'h557EA2);

        do_reset(2'd0);
        req[2] = 1'b1;
        repeat (2) tick();
        chk("mode_switch_pre_busy", busy, 1);
        mode = 2'd2;
        tick();
        chk("mode_switch_abort_busy", busy, 0);
        chk("mode_switch_abort_ack", ack, 0);
        chk("mode_switch_stall", stall, 2);
        req = '0;
        repeat (3) tick();

        do_reset(2'd0);
        for (int i = 0; i < 4000; i++) begin
            tick();
            for (int c = 0; c < NCH; c++) if ($urandom_range(7) == 0) req[c] = ~req[c];
            if ($urandom_range(99) == 0) mode = 2'($urandom_range(3));
            if (i == 2000) begin
                #2 reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/random_handshake_delay.md
Name: random_handshake_delay

Overview:
- Parametrised LFSR-driven handshake delay injector for the custom CPU simulation environment.
- Sits between the CPU's memory/bus request signals and the simulated memory model.
- Each of NUM_CH channels returns a single-cycle ack after a pseudo-random, mode-dependent delay, so CPU handshakes are stressed deterministically and reproducibly.
- Also provides a saturating stall-cycle counter for the bench to report.

Parameters:
NUM_CH, 5, number of independent request/ack channels (1..8)
LFSR_W, 23, LFSR width in bits
TAP_B, 17, second feedback tap; first tap is fixed at LFSR_W-1
SEED, 23'h557EA2, LFSR reset value; must be non-zero
DLY_W, 4, delay field width; max random delay is 2^DLY_W-1 cycles
CNT_W, 32, stall counter width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
mode  input  2  0=random, 1=no delay (pass-through), 2=short (delay masked to 2 LSBs), 3=fixed maximum delay
req  input  NUM_CH  per-channel request level; held until ack
ack  output  NUM_CH  per-channel ack; registered 1-cycle pulse (combinational in mode 1)
busy  output  1  OR over channels of (state != IDLE)
stall_cnt  output  CNT_W  saturating count of edges with any channel in WAIT
lfsr_state  output  LFSR_W  current LFSR value, for debug/seed reporting

Behaviour:
- Reset (async, any time, including mid-handshake):
  - lfsr=SEED, all channels IDLE, cnt=0, ack=0, stall_cnt=0, mode_q=0.
  - Release is synchronous to clk.
- LFSR advances every non-reset edge: next = {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1]^lfsr[TAP_B]}.
- Raw delay for channel i: d_i[k] = lfsr[(3*i+k) mod LFSR_W], k=0..DLY_W-1.
  - mode 0: d=d_i
  - mode 2: d=d_i & 2'b11 (zero-extended)
  - mode 3: d=2^DLY_W-1
- Channel FSM (per channel, independent):
  - IDLE: req=1 sampled -> WAIT, cnt<=d. req=0 -> stay.
  - WAIT: req=0 -> IDLE (abort, no ack). cnt==0 -> ACK, ack<=1. Otherwise cnt<=cnt-1.
  - ACK: ack<=0 and -> IDLE unconditionally. ack is high for exactly one cycle.
  - Latency: ack is high in the cycle starting d+1 edges after the sampling edge. Example: d=0 gives ack one cycle after the WAIT-entry edge.
  - req still high after ACK: a new request is sampled in IDLE on the next edge. Minimum ack spacing is d+3 cycles.
- mode 1 (pass-through): ack = req combinationally; FSMs held in IDLE; stall_cnt does not increment.
- Mode change:
  - mode is registered to mode_q every edge.
  - If mode != mode_q, every channel is forced to IDLE on that edge with ack<=0. In-flight handshakes are aborted.
  - Delay selection uses the live mode.
- Simultaneous requests on several channels proceed independently; all channels read the same LFSR value at their sampling edge.
- stall_cnt: +1 on each edge where any channel is in WAIT (sampled before the update). Saturates at all-ones with no wrap.
- busy is combinational from state registers.
- No X-propagation: all registers have reset values.

Test Plan:
- Reset then 1 edge, mode 0, req=0 -> lfsr_state 0x557EA2 during reset, 0x2AFD45 after first edge; ack=0, stall_cnt=0, busy=0.
- mode 3, req[0] raised and held -> ack[0] high exactly 16 cycles after the sampling edge, high one cycle only; stall_cnt=16; busy high 17 cycles.
- mode 1, toggle req=5'b10101 -> ack=5'b10101 in the same cycle; stall_cnt stays 0; busy=0.
- mode 2, all 5 channels requesting for 1000 cycles -> every ack latency is 1..4 cycles after sampling. With the same seed the full ack trace is bit-identical across two runs.
- mode 3, req[1] dropped after 5 cycles in WAIT -> no ack[1]; channel back to IDLE; stall_cnt=5. Separately, reset asserted mid-WAIT -> ack=0 and busy=0 immediately (async).
- mode 0, switch to mode 2 while channel 2 is in WAIT -> channel 2 aborts on that edge with no ack. Separately, preload CNT_W=4 and run 20 WAIT cycles -> stall_cnt saturates at 15.
